// File: rtl/apb_arb_pkg.sv
// Shared types and APB field widths for the two-master APB arbiter.
package apb_arb_pkg;

    localparam int APB_AW    = 32;
    localparam int APB_DW    = 32;
    localparam int APB_PROTW = 3;
    localparam int APB_STRBW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase cycle counter; flags the cycle in which the transfer has run TIMEOUT access cycles.
module apb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    // TIMEOUT == 0 disables the watchdog; LIMIT is then never compared.
    localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
    localparam logic            ENABLED = (TIMEOUT != 0);

    logic [TO_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = ENABLED && run && (count == LIMIT);

endmodule

// File: rtl/apb_arbiter2.sv
// Two-master APB arbiter: one SETUP/ACCESS transfer per grant, round-robin or fixed
// priority, with an ACCESS-phase watchdog that completes hung transfers with PSLVERR.
//
//   state     | meaning
//   ST_IDLE   | no transfer; arbitrate between m0_psel / m1_psel
//   ST_SETUP  | out_psel=1, out_penable=0 for the granted master
//   ST_ACCESS | out_psel=1, out_penable=1; wait for out_pready or watchdog
module apb_arbiter2
    import apb_arb_pkg::*;
#(
    parameter int unsigned RR_EN   = 1,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic [APB_AW-1:0]    m0_paddr,
    input  logic                 m0_psel,
    input  logic                 m0_penable,
    input  logic [APB_PROTW-1:0] m0_pprot,
    input  logic                 m0_pwrite,
    input  logic [APB_DW-1:0]    m0_pwdata,
    input  logic [APB_STRBW-1:0] m0_pstrb,
    output logic                 m0_pready,
    output logic [APB_DW-1:0]    m0_prdata,
    output logic                 m0_pslverr,

    input  logic [APB_AW-1:0]    m1_paddr,
    input  logic                 m1_psel,
    input  logic                 m1_penable,
    input  logic [APB_PROTW-1:0] m1_pprot,
    input  logic                 m1_pwrite,
    input  logic [APB_DW-1:0]    m1_pwdata,
    input  logic [APB_STRBW-1:0] m1_pstrb,
    output logic                 m1_pready,
    output logic [APB_DW-1:0]    m1_prdata,
    output logic                 m1_pslverr,

    output logic [APB_AW-1:0]    out_paddr,
    output logic [APB_PROTW-1:0] out_pprot,
    output logic                 out_pwrite,
    output logic [APB_DW-1:0]    out_pwdata,
    output logic [APB_STRBW-1:0] out_pstrb,
    output logic                 out_psel,
    output logic                 out_penable,
    input  logic                 out_pready,
    input  logic [APB_DW-1:0]    out_prdata,
    input  logic                 out_pslverr
);

    localparam logic RR = (RR_EN != 0);

    state_t state, state_nx;
    logic   gnt, gnt_nx;
    logic   last, last_nx;
    logic   granted_sel;
    logic   expired;
    logic   done;
    logic   resp_err;
    logic [APB_DW-1:0] resp_data;
    logic   active;

    // The granted master is in its access phase by construction, so penable is ignored.
    logic   unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign granted_sel = gnt ? m1_psel : m0_psel;
    assign active      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            last  <= last_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        last_nx     = last;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_psel || m1_psel) begin
                    state_nx = ST_SETUP;
                    if (m0_psel && m1_psel) begin
                        gnt_nx = RR ? ~last : 1'b0;
                    end else begin
                        gnt_nx = m1_psel;
                    end
                end
            end
            ST_SETUP: begin
                out_psel = 1'b1;
                state_nx = granted_sel ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                out_psel    = 1'b1;
                out_penable = 1'b1;
                // A master that withdraws its request gets no response and keeps its turn.
                if (!granted_sel) begin
                    state_nx = ST_IDLE;
                end else if (out_pready || expired) begin
                    done     = 1'b1;
                    last_nx  = gnt;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    apb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (state == ST_SETUP),
        .run     (state == ST_ACCESS),
        .expired (expired)
    );

    // A real slave response takes precedence over a simultaneous watchdog expiry.
    assign resp_err  = out_pready ? out_pslverr : 1'b1;
    assign resp_data = out_pready ? out_prdata  : '0;

    assign m0_pready  = done && !gnt;
    assign m0_pslverr = done && !gnt && resp_err;
    assign m0_prdata  = (done && !gnt) ? resp_data : '0;

    assign m1_pready  = done && gnt;
    assign m1_pslverr = done && gnt && resp_err;
    assign m1_prdata  = (done && gnt) ? resp_data : '0;

    assign out_paddr  = !active ? '0   : (gnt ? m1_paddr  : m0_paddr);
    assign out_pprot  = !active ? '0   : (gnt ? m1_pprot  : m0_pprot);
    assign out_pwrite = !active ? 1'b0 : (gnt ? m1_pwrite : m0_pwrite);
    assign out_pwdata = !active ? '0   : (gnt ? m1_pwdata : m0_pwdata);
    assign out_pstrb  = !active ? '0   : (gnt ? m1_pstrb  : m0_pstrb);

endmodule

// File: tb/tb_apb_arbiter2.sv
// Bench for apb_arbiter2: a round-robin and a fixed-priority instance share stimulus and are
// checked every cycle against a transaction-level model, plus directed tables and sequences.
module tb_apb_arbiter2;

    localparam int TO = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] paddr [2];
    logic [2:0]  pprot [2];
    logic        pwrite [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb [2];
    logic        psel [2];
    logic        penable [2];
    logic        srdy, serr;
    logic [31:0] srdata;

    logic        o_psel [2], o_pen [2], o_write [2];
    logic [31:0] o_addr [2], o_wdata [2];
    logic [2:0]  o_prot [2];
    logic [3:0]  o_strb [2];
    logic        r_rdy [2][2];
    logic        r_err [2][2];
    logic [31:0] r_dat [2][2];

    for (genvar n = 0; n < 2; n++) begin : g_dut
        apb_arbiter2 #(
            .RR_EN   ((n == 0) ? 1 : 0),
            .TIMEOUT (TO),
            .TO_W    (8)
        ) dut (
            .clock       (clk),
            .reset       (rst),
            .m0_paddr    (paddr[0]),
            .m0_psel     (psel[0]),
            .m0_penable  (penable[0]),
            .m0_pprot    (pprot[0]),
            .m0_pwrite   (pwrite[0]),
            .m0_pwdata   (pwdata[0]),
            .m0_pstrb    (pstrb[0]),
            .m0_pready   (r_rdy[n][0]),
            .m0_prdata   (r_dat[n][0]),
            .m0_pslverr  (r_err[n][0]),
            .m1_paddr    (paddr[1]),
            .m1_psel     (psel[1]),
            .m1_penable  (penable[1]),
            .m1_pprot    (pprot[1]),
            .m1_pwrite   (pwrite[1]),
            .m1_pwdata   (pwdata[1]),
            .m1_pstrb    (pstrb[1]),
            .m1_pready   (r_rdy[n][1]),
            .m1_prdata   (r_dat[n][1]),
            .m1_pslverr  (r_err[n][1]),
            .out_paddr   (o_addr[n]),
            .out_pprot   (o_prot[n]),
            .out_pwrite  (o_write[n]),
            .out_pwdata  (o_wdata[n]),
            .out_pstrb   (o_strb[n]),
            .out_psel    (o_psel[n]),
            .out_penable (o_pen[n]),
            .out_pready  (srdy),
            .out_prdata  (srdata),
            .out_pslverr (serr)
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chkv(string name, logic [141:0] act, logic [141:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Model: a transfer in flight has an owner and an age k (0 = setup, k>=1 = k-th access cycle).
    bit busy [2];
    int owner [2];
    int k [2];
    int last [2];
    logic got [2];

    function automatic logic model_done(int n);
        return busy[n] && (k[n] >= 1) && psel[owner[n]] && (srdy || (k[n] == TO));
    endfunction

    function automatic logic [141:0] exp_vec(int n);
        logic        ps = 1'b0, pe = 1'b0, w = 1'b0;
        logic [31:0] a = '0, wd = '0;
        logic [2:0]  pr = '0;
        logic [3:0]  st = '0;
        logic [33:0] resp [2];
        resp[0] = '0;
        resp[1] = '0;
        if (busy[n]) begin
            ps = 1'b1;
            pe = (k[n] >= 1);
            a  = paddr[owner[n]];
            pr = pprot[owner[n]];
            w  = pwrite[owner[n]];
            wd = pwdata[owner[n]];
            st = pstrb[owner[n]];
            if (model_done(n))
                resp[owner[n]] = {1'b1, (srdy ? serr : 1'b1), (srdy ? srdata : 32'h0)};
        end
        return {ps, pe, a, pr, w, wd, st, resp[0], resp[1]};
    endfunction

    function automatic logic [141:0] act_vec(int n);
        return {o_psel[n], o_pen[n], o_addr[n], o_prot[n], o_write[n], o_wdata[n], o_strb[n],
                r_rdy[n][0], r_err[n][0], r_dat[n][0], r_rdy[n][1], r_err[n][1], r_dat[n][1]};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            busy[n] = 1'b0; owner[n] = 0; k[n] = 0; last[n] = 1;
        end
    endtask

    task automatic model_step(int n);
        if (!rst) begin
            busy[n] = 1'b0; owner[n] = 0; k[n] = 0; last[n] = 1;
        end else if (!busy[n]) begin
            if (psel[0] || psel[1]) begin
                busy[n] = 1'b1;
                k[n]    = 0;
                if (psel[0] && psel[1]) owner[n] = (n == 0) ? 1 - last[n] : 0;
                else                    owner[n] = psel[1] ? 1 : 0;
            end
        end else if (!psel[owner[n]]) begin
            busy[n] = 1'b0;
        end else if (k[n] == 0) begin
            k[n] = 1;
        end else if (srdy || (k[n] == TO)) begin
            busy[n] = 1'b0;
            last[n] = owner[n];
        end else begin
            k[n] = k[n] + 1;
        end
    endtask

    task automatic settle_check();
        #1;
        for (int n = 0; n < 2; n++) chkv($sformatf("model_inst%0d", n), act_vec(n), exp_vec(n));
        for (int i = 0; i < 2; i++) got[i] = model_done(0) && (owner[0] == i);
    endtask

    task automatic clock_step();
        @(posedge clk);
        for (int n = 0; n < 2; n++) model_step(n);
        @(negedge clk);
    endtask

    task automatic tick();
        settle_check();
        clock_step();
    endtask

    typedef struct {
        logic p0, p1, srdy, serr;
        logic [31:0] srd;
        logic e_psel, e_pen;
        logic [31:0] e_addr;
        logic e_r0, e_e0;
        logic [31:0] e_d0;
        logic e_r1, e_e1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl [9];
    int   seq_a [$];
    int   seq_b [$];
    int   t_a [$];

    initial begin
        tbl[0] = '{H, L, L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0};
        tbl[1] = '{H, L, L, L, 32'h0,         H, L, 32'h0000_A000, L, L, 32'h0,         L, L, 32'h0};
        tbl[2] = '{H, L, L, L, 32'h0,         H, H, 32'h0000_A000, L, L, 32'h0,         L, L, 32'h0};
        tbl[3] = '{H, L, H, H, 32'h5555_AAAA, H, H, 32'h0000_A000, H, H, 32'h5555_AAAA, L, L, 32'h0};
        tbl[4] = '{L, L, L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0};
        tbl[5] = '{L, H, L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0};
        tbl[6] = '{L, H, L, L, 32'h0,         H, L, 32'h1000_0004, L, L, 32'h0,         L, L, 32'h0};
        tbl[7] = '{L, H, H, L, 32'hDEAD_BEEF, H, H, 32'h1000_0004, L, L, 32'h0,         H, L, 32'hDEAD_BEEF};
        tbl[8] = '{L, L, L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0};

        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pprot[i] = 3'd0; pwrite[i] = 1'b0;
            pwdata[i] = 32'h0; pstrb[i] = 4'h0; got[i] = 1'b0;
        end
        paddr[0] = 32'h0000_A000;
        paddr[1] = 32'h1000_0004;
        srdy = 1'b0; serr = 1'b0; srdata = 32'h0;

        // Reset held with a pending request, then released.
        rst = 1'b0;
        model_reset();
        psel[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle_check();
            chk1("rst_out_psel", o_psel[0], 1'b0);
            chk1("rst_m0_pready", r_rdy[0][0], 1'b0);
            clock_step();
        end
        rst = 1'b1;
        settle_check();
        chk1("rel_idle_psel", o_psel[0], 1'b0);
        clock_step();
        settle_check();
        chk1("rel_setup_psel", o_psel[0], 1'b1);
        chk32("rel_setup_addr", o_addr[0], 32'h0000_A000);
        clock_step();
        srdy = 1'b1; srdata = 32'h0BAD_F00D;
        settle_check();
        chk1("first_rdy", r_rdy[0][0], 1'b1);
        chk32("first_data", r_dat[0][0], 32'h0BAD_F00D);
        clock_step();
        psel[0] = 1'b0; srdy = 1'b0;
        tick();

        // Cycle-by-cycle vectors: m0 error read with a wait state, then m1 zero-wait read.
        for (int r = 0; r < 9; r++) begin
            psel[0] = tbl[r].p0; psel[1] = tbl[r].p1;
            srdy = tbl[r].srdy; serr = tbl[r].serr; srdata = tbl[r].srd;
            settle_check();
            chkv($sformatf("tbl_row%0d", r),
                 {40'b0, o_psel[0], o_pen[0], o_addr[0], r_rdy[0][0], r_err[0][0], r_dat[0][0],
                  r_rdy[0][1], r_err[0][1], r_dat[0][1]},
                 {40'b0, tbl[r].e_psel, tbl[r].e_pen, tbl[r].e_addr, tbl[r].e_r0, tbl[r].e_e0,
                  tbl[r].e_d0, tbl[r].e_r1, tbl[r].e_e1, tbl[r].e_d1});
            clock_step();
        end

        // Both masters request continuously with a zero-wait slave.
        psel[0] = 1'b1; psel[1] = 1'b1; srdy = 1'b1; serr = 1'b0; srdata = 32'h600D_0000;
        for (int c = 0; c < 40 && seq_a.size() < 4; c++) begin
            settle_check();
            for (int m = 0; m < 2; m++) begin
                if (r_rdy[0][m]) begin
                    seq_a.push_back(m);
                    t_a.push_back(c);
                end
                if (r_rdy[1][m]) seq_b.push_back(m);
            end
            clock_step();
        end
        chk32("rr_count", seq_a.size(), 32'd4);
        chk32("fp_count", seq_b.size(), 32'd4);
        for (int i = 0; i < seq_a.size(); i++) begin
            chk32($sformatf("rr_order%0d", i), seq_a[i], i % 2);
            if (i > 0) chk32($sformatf("rr_gap%0d", i), t_a[i] - t_a[i-1], 32'd3);
        end
        for (int i = 0; i < seq_b.size(); i++) chk32($sformatf("fp_order%0d", i), seq_b[i], 32'd0);
        psel[0] = 1'b0; psel[1] = 1'b0; srdy = 1'b0;
        tick();
        tick();

        // Watchdog: slave never ready.
        psel[0] = 1'b1; srdata = 32'hFFFF_FFFF;
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            settle_check();
            chk1("to_wait_rdy", r_rdy[0][0], 1'b0);
            clock_step();
        end
        settle_check();
        chk1("to_rdy", r_rdy[0][0], 1'b1);
        chk1("to_err", r_err[0][0], 1'b1);
        chk32("to_data", r_dat[0][0], 32'h0);
        clock_step();
        psel[0] = 1'b0;
        settle_check();
        chk1("to_psel_after", o_psel[0], 1'b0);
        clock_step();

        // m1 completes (last=m1), then m0 write aborted in SETUP must leave last alone.
        psel[1] = 1'b1; srdy = 1'b1; srdata = 32'h0;
        tick();
        tick();
        tick();
        psel[1] = 1'b0; srdy = 1'b0;
        psel[0] = 1'b1; pwrite[0] = 1'b1; pwdata[0] = 32'h1234_5678; pstrb[0] = 4'b0011;
        tick();
        psel[0] = 1'b0;
        settle_check();
        chk1("ab_setup_psel", o_psel[0], 1'b1);
        chk32("ab_wdata", o_wdata[0], 32'h1234_5678);
        chk32("ab_strb", 32'(o_strb[0]), 32'h3);
        chk1("ab_write", o_write[0], 1'b1);
        chk1("ab_setup_rdy", r_rdy[0][0], 1'b0);
        clock_step();
        settle_check();
        chk1("ab_idle_psel", o_psel[0], 1'b0);
        chk1("ab_idle_rdy", r_rdy[0][0], 1'b0);
        clock_step();
        psel[0] = 1'b1; psel[1] = 1'b1;
        tick();
        settle_check();
        chk32("ab_regrant_addr", o_addr[0], 32'h0000_A000);
        clock_step();
        srdy = 1'b1;
        tick();
        psel[0] = 1'b0; psel[1] = 1'b0; srdy = 1'b0;
        tick();

        // Reset asserted in the middle of an ACCESS phase.
        psel[1] = 1'b1;
        tick();
        tick();
        settle_check();
        chk1("mr_access_pen", o_pen[0], 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        chk1("mr_psel_rr", o_psel[0], 1'b0);
        chk1("mr_psel_fp", o_psel[1], 1'b0);
        clock_step();
        rst = 1'b1; psel[1] = 1'b0;
        tick();

        // Random traffic; masters drop psel after the model's predicted completion or abort rarely.
        for (int i = 0; i < 2; i++) got[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (psel[i]) begin
                    if (got[i] || ($urandom_range(39) == 0)) psel[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    psel[i] = 1'b1;
                    paddr[i]  = $urandom();
                    pprot[i]  = 3'($urandom_range(7));
                    pwrite[i] = 1'($urandom_range(1));
                    pwdata[i] = $urandom();
                    pstrb[i]  = 4'($urandom_range(15));
                end
                if (!psel[i]) begin
                    paddr[i]  = $urandom();
                    pwdata[i] = $urandom();
                end
                penable[i] = psel[i] & 1'($urandom_range(1));
            end
            srdy   = ($urandom_range(2) == 0);
            serr   = ($urandom_range(3) == 0);
            srdata = $urandom();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
